// File: rtl/get_stream_checker_pkg.sv
// Shared types and constants for the get-stream checker and its LFSR.
package get_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/get_stream_checker_lfsr16.sv
// 16-bit right-shifting Galois LFSR with enable and synchronous seed load.
module lfsr16
    import get_check_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT,
    parameter logic [15:0] TAPS = LFSR_TAPS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] lfsr_out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (en) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/get_stream_checker.sv
// Drains a programmed number of words from a get stream, checks them against
// start + k*stride and reports pass/fail, error details, count and sum.
module get_stream_checker
    import get_check_pkg::*;
#(
    parameter int          W         = 32,
    parameter int          CNT_W     = 8,
    parameter int          TIMEOUT   = 255,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rdy_get,
    input  logic [W-1:0]     get_data,
    output logic             en_get,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [W-1:0]     cfg_first,
    input  logic [W-1:0]     cfg_stride,
    input  logic             throttle_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [W-1:0]     first_err_data,
    output logic [W-1:0]     sum
);

    localparam int               TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMO_V = TMR_W'(TIMEOUT);

    state_t state_q, state_d;

    logic [CNT_W-1:0] cfg_count_q, cfg_count_d;
    logic [W-1:0]     cfg_stride_q, cfg_stride_d;
    logic             throttle_q, throttle_d;
    logic [W-1:0]     exp_q, exp_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [W-1:0]     first_err_data_q, first_err_data_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;

    logic [15:0]      lfsr_state;
    logic             lfsr_adv;
    logic             beat;
    logic [CNT_W-1:0] wc_inc;
    logic             last_beat;
    logic             idle_expire;

    assign lfsr_adv = (state_q == ST_RUN);

    lfsr16 #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .en       (lfsr_adv),
        .load     (1'b0),
        .seed     (LFSR_SEED),
        .lfsr_out (lfsr_state)
    );

    assign beat      = en_get;
    assign wc_inc    = word_count_q + 1'b1;
    assign last_beat = beat && (wc_inc == cfg_count_q);
    // A beat clears the idle timer, so a completing beat can never also time out.
    assign idle_expire = (TIMEOUT != 0) && !beat && ((timer_q + 1'b1) == TMO_V);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (cfg_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_beat || idle_expire) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; en_get is gated by reset so upstream never loses a word to an abort.
    always_comb begin
        en_get = reset && (state_q == ST_RUN) && rdy_get &&
                 (!throttle_q || lfsr_state[0]);
        busy   = (state_q == ST_RUN);
        done   = (state_q == ST_DONE);
    end

    // Datapath next-value logic
    always_comb begin
        cfg_count_d      = cfg_count_q;
        cfg_stride_d     = cfg_stride_q;
        throttle_d       = throttle_q;
        exp_d            = exp_q;
        word_count_d     = word_count_q;
        err_count_d      = err_count_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_data_d = first_err_data_q;
        sum_d            = sum_q;
        timer_d          = timer_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;

        if ((state_q != ST_RUN) && start) begin
            cfg_count_d      = cfg_count;
            cfg_stride_d     = cfg_stride;
            throttle_d       = throttle_en;
            exp_d            = cfg_first;
            word_count_d     = '0;
            err_count_d      = '0;
            first_err_idx_d  = '0;
            first_err_data_d = '0;
            sum_d            = '0;
            timer_d          = '0;
            pass_d           = (cfg_count == '0);
            timeout_d        = 1'b0;
        end else if (state_q == ST_RUN) begin
            timer_d = beat ? '0 : timer_q + 1'b1;
            if (beat) begin
                word_count_d = wc_inc;
                sum_d        = sum_q + get_data;
                exp_d        = exp_q + cfg_stride_q;
                if (get_data != exp_q) begin
                    if (err_count_q != {CNT_W{1'b1}}) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    if (err_count_q == '0) begin
                        first_err_idx_d  = word_count_q;
                        first_err_data_d = get_data;
                    end
                end
            end
            if (last_beat) begin
                pass_d = (err_count_d == '0);
            end else if (idle_expire) begin
                timeout_d = 1'b1;
                pass_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_count_q      <= '0;
            cfg_stride_q     <= '0;
            throttle_q       <= 1'b0;
            exp_q            <= '0;
            word_count_q     <= '0;
            err_count_q      <= '0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
            sum_q            <= '0;
            timer_q          <= '0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            cfg_count_q      <= cfg_count_d;
            cfg_stride_q     <= cfg_stride_d;
            throttle_q       <= throttle_d;
            exp_q            <= exp_d;
            word_count_q     <= word_count_d;
            err_count_q      <= err_count_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_data_q <= first_err_data_d;
            sum_q            <= sum_d;
            timer_q          <= timer_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
        end
    end

    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign word_count     = word_count_q;
    assign err_count      = err_count_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_data = first_err_data_q;
    assign sum            = sum_q;

endmodule

// File: tb/tb_get_stream_checker.sv
// Self-checking bench: a list-based model of the received stream checked every
// cycle, plus hand-computed expectations per directed run.
module tb_get_stream_checker;

    localparam int W     = 32;
    localparam int CNT_W = 8;
    localparam int TMO   = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             rdy_get = 1'b0;
    logic [W-1:0]     get_data = '0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic [W-1:0]     cfg_first = '0;
    logic [W-1:0]     cfg_stride = '0;
    logic             throttle_en = 1'b0;
    logic             en_get, busy, done, pass, timeout;
    logic [CNT_W-1:0] word_count, err_count, first_err_idx;
    logic [W-1:0]     first_err_data, sum;

    get_stream_checker #(
        .W         (W),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TMO),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rdy_get        (rdy_get),
        .get_data       (get_data),
        .en_get         (en_get),
        .start          (start),
        .cfg_count      (cfg_count),
        .cfg_first      (cfg_first),
        .cfg_stride     (cfg_stride),
        .throttle_en    (throttle_en),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .word_count     (word_count),
        .err_count      (err_count),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data),
        .sum            (sum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: run configuration plus the list of words actually accepted.
    int           m_state = 0;   // 0 idle, 1 run, 2 done
    logic [15:0]  m_lfsr = 16'hACE1;
    int           m_timer = 0;
    logic [W-1:0] m_first = '0;
    logic [W-1:0] m_stride = '0;
    int           m_count = 0;
    bit           m_thr = 1'b0;
    bit           m_pass = 1'b0;
    bit           m_tmo = 1'b0;
    logic [W-1:0] m_rx[$];

    function automatic int model_errs();
        int e = 0;
        for (int i = 0; i < m_rx.size(); i++) begin
            if (m_rx[i] != m_first + W'(i) * m_stride) e++;
        end
        return e;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            begin
                bit           m_en;
                int           errs;
                int           fi;
                logic [W-1:0] fd;
                logic [W-1:0] s;
                m_en = reset && (m_state == 1) && rdy_get && (!m_thr || m_lfsr[0]);
                errs = 0; fi = 0; fd = '0; s = '0;
                for (int i = 0; i < m_rx.size(); i++) begin
                    s = s + m_rx[i];
                    if (m_rx[i] != m_first + W'(i) * m_stride) begin
                        if (errs == 0) begin
                            fi = i;
                            fd = m_rx[i];
                        end
                        errs++;
                    end
                end
                if (chk_en) begin
                    check("en_get", 64'(en_get), 64'(m_en));
                    check("busy", 64'(busy), 64'(m_state == 1));
                    check("done", 64'(done), 64'(m_state == 2));
                    check("pass", 64'(pass), 64'(m_pass));
                    check("timeout", 64'(timeout), 64'(m_tmo));
                    check("word_count", 64'(word_count), 64'(m_rx.size()));
                    check("err_count", 64'(err_count), 64'((errs > 255) ? 255 : errs));
                    check("first_err_idx", 64'(first_err_idx), 64'(fi));
                    check("first_err_data", 64'(first_err_data), 64'(fd));
                    check("sum", 64'(sum), 64'(s));
                end
                // Advance the model to what the coming posedge must produce.
                if (!reset) begin
                    m_state = 0; m_lfsr = 16'hACE1; m_timer = 0; m_rx.delete();
                    m_first = '0; m_stride = '0; m_count = 0; m_thr = 1'b0;
                    m_pass = 1'b0; m_tmo = 1'b0;
                end else if (m_state != 1) begin
                    if (start) begin
                        m_first = cfg_first; m_stride = cfg_stride;
                        m_count = int'(cfg_count); m_thr = throttle_en;
                        m_rx.delete(); m_timer = 0; m_tmo = 1'b0;
                        if (cfg_count == '0) begin
                            m_state = 2; m_pass = 1'b1;
                        end else begin
                            m_state = 1; m_pass = 1'b0;
                        end
                    end
                end else begin
                    if (m_en) begin
                        m_rx.push_back(get_data);
                        m_timer = 0;
                    end else begin
                        m_timer++;
                    end
                    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
                    if (m_en && m_rx.size() == m_count) begin
                        m_state = 2;
                        m_pass  = (model_errs() == 0);
                    end else if (!m_en && TMO != 0 && m_timer == TMO) begin
                        m_state = 2; m_tmo = 1'b1; m_pass = 1'b0;
                    end
                end
            end
        end
    end

    // Upstream source: presents src[src_idx], advancing on each accepted beat.
    logic [W-1:0] src[16];
    int           src_idx = 0;

    task automatic tick(output bit beat);
        @(negedge clk);
        beat = en_get;
        @(posedge clk);
        #1;
        if (beat) src_idx++;
        get_data = (src_idx < 16) ? src[src_idx] : '0;
    endtask

    task automatic do_reset();
        bit b;
        reset = 1'b0; start = 1'b0; rdy_get = 1'b0;
        tick(b);
        reset = 1'b1;
    endtask

    task automatic load_src(input bit bad);
        for (int i = 0; i < 16; i++) src[i] = W'(4 * i);
        if (bad) src[2] = 32'd9;
    endtask

    task automatic run_test(input logic [CNT_W-1:0] cnt, input logic [W-1:0] first,
                            input logic [W-1:0] stride, input bit thr, input int rmode,
                            output int edges, output int mask);
        bit b;
        src_idx = 0; get_data = src[0];
        cfg_count = cnt; cfg_first = first; cfg_stride = stride; throttle_en = thr;
        start = 1'b1; rdy_get = 1'b0;
        tick(b);
        start = 1'b0;
        // Scramble config to show it was latched on start.
        cfg_count = '1; cfg_first = '1; cfg_stride = 32'h1234_5678; throttle_en = ~thr;
        edges = 0; mask = 0;
        while (!done && edges < 200) begin
            case (rmode)
                0:       rdy_get = 1'b1;
                1:       rdy_get = (edges % 2 == 0);
                default: rdy_get = (edges < 2);
            endcase
            tick(b);
            if (b && edges < 32) mask |= (1 << edges);
            edges++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    initial begin
        int e, m;
        bit b;
        load_src(1'b0);
        do_reset();
        chk_en = 1'b1;

        // Contiguous stream
        run_test(8'd6, 32'd0, 32'd4, 1'b0, 0, e, m);
        $display("run contiguous: edges=%0d pass=%0b sum=%0d wc=%0d", e, pass, sum, word_count);
        check("t1_edges", 64'(e), 64'd6);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_sum", 64'(sum), 64'd60);
        check("t1_wc", 64'(word_count), 64'd6);

        // Alternating rdy_get
        run_test(8'd6, 32'd0, 32'd4, 1'b0, 1, e, m);
        $display("run toggle rdy: edges=%0d mask=0x%0h pass=%0b sum=%0d", e, m, pass, sum);
        check("t2_edges", 64'(e), 64'd11);
        check("t2_mask", 64'(m), 64'h555);
        check("t2_pass", 64'(pass), 64'd1);
        check("t2_sum", 64'(sum), 64'd60);

        // One corrupted word
        load_src(1'b1);
        run_test(8'd6, 32'd0, 32'd4, 1'b0, 0, e, m);
        $display("run bad word: pass=%0b err=%0d idx=%0d data=%0d sum=%0d",
                 pass, err_count, first_err_idx, first_err_data, sum);
        check("t3_pass", 64'(pass), 64'd0);
        check("t3_err", 64'(err_count), 64'd1);
        check("t3_idx", 64'(first_err_idx), 64'd2);
        check("t3_data", 64'(first_err_data), 64'd9);
        check("t3_sum", 64'(sum), 64'd61);

        // Upstream stalls after two words
        load_src(1'b0);
        run_test(8'd6, 32'd0, 32'd4, 1'b0, 2, e, m);
        $display("run timeout: edges=%0d timeout=%0b pass=%0b wc=%0d", e, timeout, pass, word_count);
        check("t4_edges", 64'(e), 64'd12);
        check("t4_timeout", 64'(timeout), 64'd1);
        check("t4_pass", 64'(pass), 64'd0);
        check("t4_wc", 64'(word_count), 64'd2);

        // Reset after the third beat
        src_idx = 0; get_data = src[0];
        cfg_count = 8'd6; cfg_first = 32'd0; cfg_stride = 32'd4; throttle_en = 1'b0;
        start = 1'b1; tick(b); start = 1'b0;
        rdy_get = 1'b1;
        for (int i = 0; i < 3; i++) tick(b);
        reset = 1'b0;
        tick(b);
        check("t6_en_in_reset", 64'(b), 64'd0);
        reset = 1'b1;
        #1;
        $display("reset mid-run: busy=%0b done=%0b wc=%0d sum=%0d", busy, done, word_count, sum);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_wc", 64'(word_count), 64'd0);
        check("t6_sum", 64'(sum), 64'd0);
        run_test(8'd6, 32'd0, 32'd4, 1'b0, 0, e, m);
        $display("run after reset: pass=%0b sum=%0d", pass, sum);
        check("t6_pass", 64'(pass), 64'd1);
        check("t6_sum2", 64'(sum), 64'd60);

        // Throttled run from a fresh LFSR
        do_reset();
        run_test(8'd6, 32'd0, 32'd4, 1'b1, 0, e, m);
        $display("run throttled: edges=%0d mask=0x%0h pass=%0b sum=%0d", e, m, pass, sum);
        check("t5_edges", 64'(e), 64'd15);
        check("t5_mask", 64'(m), 64'h44E1);
        check("t5_pass", 64'(pass), 64'd1);
        rdy_get = 1'b1;
        for (int i = 0; i < 3; i++) tick(b);
        check("t5_no_extra", 64'(src_idx), 64'd6);

        // Zero-length run
        run_test(8'd0, 32'd0, 32'd4, 1'b0, 0, e, m);
        $display("run zero count: edges=%0d pass=%0b wc=%0d", e, pass, word_count);
        check("t7_edges", 64'(e), 64'd0);
        check("t7_pass", 64'(pass), 64'd1);
        check("t7_wc", 64'(word_count), 64'd0);

        tick(b);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
